// File: rtl/vx_mem_credit_arb.sv
// rtl/vx_mem_credit_arb.sv - credit-gated round-robin arbiter sharing one memory port
module vx_mem_credit_arb #(
    parameter int NUM_REQS      = 4,
    parameter int ADDR_WIDTH    = 26,
    parameter int DATA_WIDTH    = 512,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int MAX_PENDING   = 16,
    parameter int LOG_NUM_REQS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                req_valid_in,
    input  logic [NUM_REQS-1:0]                req_rw_in,
    input  logic [NUM_REQS*DATA_WIDTH/8-1:0]   req_byteen_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]     req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]   req_tag_in,
    output logic [NUM_REQS-1:0]                req_ready_in,
    output logic                               req_valid_out,
    output logic                               req_rw_out,
    output logic [DATA_WIDTH/8-1:0]            req_byteen_out,
    output logic [ADDR_WIDTH-1:0]              req_addr_out,
    output logic [DATA_WIDTH-1:0]              req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]           req_tag_out,
    input  logic                               req_ready_out,
    input  logic                               rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]              rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]           rsp_tag_in,
    output logic                               rsp_ready_in,
    output logic [NUM_REQS-1:0]                rsp_valid_out,
    output logic [NUM_REQS*DATA_WIDTH-1:0]     rsp_data_out,
    output logic [NUM_REQS*TAG_IN_WIDTH-1:0]   rsp_tag_out,
    input  logic [NUM_REQS-1:0]                rsp_ready_out,
    output logic                               busy
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int IDX_W = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    // Per-requester views of the packed request buses
    logic [BE_W-1:0]         byteen_arr [NUM_REQS];
    logic [ADDR_WIDTH-1:0]   addr_arr   [NUM_REQS];
    logic [DATA_WIDTH-1:0]   data_arr   [NUM_REQS];
    logic [TAG_IN_WIDTH-1:0] tag_arr    [NUM_REQS];

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign byteen_arr[g] = req_byteen_in[g*BE_W +: BE_W];
        assign addr_arr[g]   = req_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g]   = req_data_in[g*DATA_WIDTH +: DATA_WIDTH];
        assign tag_arr[g]    = req_tag_in[g*TAG_IN_WIDTH +: TAG_IN_WIDTH];
    end

    // State
    logic                     stage_valid_q,  stage_valid_d;
    logic                     stage_rw_q,     stage_rw_d;
    logic [BE_W-1:0]          stage_byteen_q, stage_byteen_d;
    logic [ADDR_WIDTH-1:0]    stage_addr_q,   stage_addr_d;
    logic [DATA_WIDTH-1:0]    stage_data_q,   stage_data_d;
    logic [TAG_OUT_WIDTH-1:0] stage_tag_q,    stage_tag_d;
    logic [IDX_W-1:0]         rr_ptr_q,       rr_ptr_d;
    logic [CNT_W-1:0]         cnt_q [NUM_REQS];
    logic [CNT_W-1:0]         cnt_d [NUM_REQS];

    // Arbitration / response signals
    logic [NUM_REQS-1:0]      eligible;
    logic [IDX_W-1:0]         cand;
    logic [IDX_W-1:0]         grant;
    logic                     any_eligible;
    logic                     can_load;
    logic                     accept;
    logic [TAG_OUT_WIDTH-1:0] grant_tag;
    logic [IDX_W-1:0]         rsp_idx;
    logic                     rsp_idx_ok;
    logic [TAG_IN_WIDTH-1:0]  rsp_tag_stripped;
    logic                     rsp_fire;
    logic [NUM_REQS-1:0]      cnt_inc;
    logic [NUM_REQS-1:0]      cnt_dec;

    // Index field only exists when there is more than one requester
    if (LOG_NUM_REQS > 0) begin : g_idx
        assign grant_tag        = {tag_arr[grant], grant};
        assign rsp_idx          = rsp_tag_in[LOG_NUM_REQS-1:0];
        assign rsp_tag_stripped = rsp_tag_in[TAG_OUT_WIDTH-1:LOG_NUM_REQS];
    end else begin : g_noidx
        assign grant_tag        = tag_arr[0];
        assign rsp_idx          = '0;
        assign rsp_tag_stripped = rsp_tag_in;
    end

    // Out-of-range indices are only possible when NUM_REQS is not a power of two
    if ((1 << LOG_NUM_REQS) == NUM_REQS) begin : g_idx_full
        assign rsp_idx_ok = 1'b1;
    end else begin : g_idx_part
        assign rsp_idx_ok = (32'(rsp_idx) < NUM_REQS);
    end

    // A reader is held off once it has MAX_PENDING reads in flight; writes are never gated
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = req_valid_in[i] && (req_rw_in[i] || (cnt_q[i] < CNT_MAX));
        end
    end

    // Round-robin search from rr_ptr; descending offsets so the nearest eligible wins
    always_comb begin
        grant        = '0;
        cand         = '0;
        any_eligible = 1'b0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQS);
            if (eligible[cand]) begin
                grant        = cand;
                any_eligible = 1'b1;
            end
        end
    end

    // Stage loads when empty or draining this cycle; nothing is accepted during reset
    always_comb begin
        can_load = !stage_valid_q || req_ready_out;
        accept   = any_eligible && can_load && !reset;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready_in[i] = accept && (grant == IDX_W'(i));
        end
    end

    // Response routing by the index carried in the tag LSBs
    always_comb begin
        rsp_ready_in = rsp_idx_ok && rsp_ready_out[rsp_idx];
        rsp_fire     = rsp_valid_in && rsp_ready_in;
        for (int i = 0; i < NUM_REQS; i++) begin
            rsp_valid_out[i] = rsp_valid_in && rsp_idx_ok && (rsp_idx == IDX_W'(i));
        end
        rsp_data_out = {NUM_REQS{rsp_data_in}};
        rsp_tag_out  = {NUM_REQS{rsp_tag_stripped}};
    end

    // Next state for the request stage and round-robin pointer
    always_comb begin
        stage_valid_d  = stage_valid_q;
        stage_rw_d     = stage_rw_q;
        stage_byteen_d = stage_byteen_q;
        stage_addr_d   = stage_addr_q;
        stage_data_d   = stage_data_q;
        stage_tag_d    = stage_tag_q;
        rr_ptr_d       = rr_ptr_q;
        if (accept) begin
            stage_valid_d  = 1'b1;
            stage_rw_d     = req_rw_in[grant];
            stage_byteen_d = byteen_arr[grant];
            stage_addr_d   = addr_arr[grant];
            stage_data_d   = data_arr[grant];
            stage_tag_d    = grant_tag;
            rr_ptr_d       = (int'(grant) == NUM_REQS - 1) ? '0 : grant + IDX_W'(1);
        end else if (req_ready_out) begin
            stage_valid_d = 1'b0;
        end
    end

    // Credit counters: read accept adds, response fire removes, both together cancel
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            cnt_inc[i] = accept && !req_rw_in[grant] && (grant == IDX_W'(i));
            cnt_dec[i] = rsp_fire && (rsp_idx == IDX_W'(i));
            cnt_d[i]   = cnt_q[i];
            if (cnt_inc[i] && !cnt_dec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Busy whenever a request is staged or any read is still outstanding
    always_comb begin
        busy = stage_valid_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (cnt_q[i] != '0) begin
                busy = 1'b1;
            end
        end
    end

    // Registered state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q  <= 1'b0;
            stage_rw_q     <= 1'b0;
            stage_byteen_q <= '0;
            stage_addr_q   <= '0;
            stage_data_q   <= '0;
            stage_tag_q    <= '0;
            rr_ptr_q       <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stage_valid_q  <= stage_valid_d;
            stage_rw_q     <= stage_rw_d;
            stage_byteen_q <= stage_byteen_d;
            stage_addr_q   <= stage_addr_d;
            stage_data_q   <= stage_data_d;
            stage_tag_q    <= stage_tag_d;
            rr_ptr_q       <= rr_ptr_d;
            for (int i = 0; i < NUM_REQS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Memory-side outputs come straight from the stage register
    always_comb begin
        req_valid_out  = stage_valid_q;
        req_rw_out     = stage_rw_q;
        req_byteen_out = stage_byteen_q;
        req_addr_out   = stage_addr_q;
        req_data_out   = stage_data_q;
        req_tag_out    = stage_tag_q;
    end

    // Response index range, no response without credit, no credit overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!rsp_valid_in || rsp_idx_ok);
            assert (!rsp_fire || (cnt_q[rsp_idx] != '0));
            for (int i = 0; i < NUM_REQS; i++) begin
                assert (!(cnt_inc[i] && !cnt_dec[i] && (cnt_q[i] == CNT_MAX)));
            end
        end
    end

endmodule

// File: tb/tb_vx_mem_credit_arb.sv
// tb/tb_vx_mem_credit_arb.sv - randomized and directed bench for vx_mem_credit_arb
module tb_vx_mem_credit_arb;

    localparam int N   = 4;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int MP  = 2;
    localparam int BW  = DW / 8;
    localparam int TOW = TW + 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid_in, req_rw_in, req_ready_in;
    logic [N*BW-1:0] req_byteen_in;
    logic [N*AW-1:0] req_addr_in;
    logic [N*DW-1:0] req_data_in;
    logic [N*TW-1:0] req_tag_in;
    logic            req_valid_out, req_rw_out, req_ready_out;
    logic [BW-1:0]   req_byteen_out;
    logic [AW-1:0]   req_addr_out;
    logic [DW-1:0]   req_data_out;
    logic [TOW-1:0]  req_tag_out;
    logic            rsp_valid_in, rsp_ready_in;
    logic [DW-1:0]   rsp_data_in;
    logic [TOW-1:0]  rsp_tag_in;
    logic [N-1:0]    rsp_valid_out, rsp_ready_out;
    logic [N*DW-1:0] rsp_data_out;
    logic [N*TW-1:0] rsp_tag_out;
    logic            busy;

    vx_mem_credit_arb #(
        .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
        .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_in(req_ready_in),
        .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
        .req_addr_out(req_addr_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
        .rsp_ready_in(rsp_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
        .rsp_ready_out(rsp_ready_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: outstanding reads per requester, rotating priority, one staged request
    int          m_cnt [N];
    int          m_rr;
    bit          m_sv;
    logic        m_rw;
    logic [BW-1:0]  m_be;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_data;
    logic [TOW-1:0] m_tag;
    int          m_grant, m_ridx;
    bit          m_acc, m_fire;
    logic [N-1:0] exp_ready, exp_rsp_valid;
    logic         exp_rsp_ready, exp_busy;

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr = 0;
        m_sv = 0;
    endtask

    task automatic model_eval();
        bit found;
        #1;
        found = 0;
        m_grant = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (!found && req_valid_in[i] && (req_rw_in[i] || m_cnt[i] < MP)) begin
                found = 1;
                m_grant = i;
            end
        end
        m_acc = found && (!m_sv || req_ready_out) && !reset;
        exp_ready = '0;
        if (m_acc) exp_ready[m_grant] = 1'b1;
        m_ridx = int'(rsp_tag_in[1:0]);
        exp_rsp_valid = '0;
        if (rsp_valid_in) exp_rsp_valid[m_ridx] = 1'b1;
        exp_rsp_ready = rsp_ready_out[m_ridx];
        m_fire = rsp_valid_in && rsp_ready_out[m_ridx] && !reset;
        exp_busy = m_sv;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) exp_busy = 1'b1;
    endtask

    task automatic clk_cycle();
        model_eval();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (m_acc) begin
                m_sv   = 1;
                m_rw   = req_rw_in[m_grant];
                m_be   = req_byteen_in[m_grant*BW +: BW];
                m_addr = req_addr_in[m_grant*AW +: AW];
                m_data = req_data_in[m_grant*DW +: DW];
                m_tag  = {req_tag_in[m_grant*TW +: TW], 2'(m_grant)};
                if (!req_rw_in[m_grant]) m_cnt[m_grant]++;
                m_rr = (m_grant + 1) % N;
            end else if (req_ready_out) begin
                m_sv = 0;
            end
            if (m_fire) m_cnt[m_ridx]--;
        end
        #1;
    endtask

    task automatic idle();
        req_valid_in = '0;
        req_rw_in = '0;
        rsp_valid_in = 1'b0;
        rsp_tag_in = '0;
        rsp_data_in = '0;
        rsp_ready_out = '0;
    endtask

    task automatic set_req(input int i, input bit rw);
        req_valid_in[i] = 1'b1;
        req_rw_in[i] = rw;
        req_addr_in[i*AW +: AW] = AW'($urandom);
        req_data_in[i*DW +: DW] = $urandom;
        req_byteen_in[i*BW +: BW] = BW'($urandom);
        req_tag_in[i*TW +: TW] = TW'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        idle();
        req_ready_out = 1'b1;
        while ((m_sv || m_cnt[0] != 0 || m_cnt[1] != 0 || m_cnt[2] != 0 || m_cnt[3] != 0) && guard < 40) begin
            rsp_valid_in = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!rsp_valid_in && m_cnt[i] != 0) begin
                    rsp_valid_in = 1'b1;
                    rsp_tag_in = {TW'($urandom), 2'(i)};
                    rsp_data_in = $urandom;
                end
            end
            rsp_ready_out = '1;
            model_eval();
            n_vec++;
            if (rsp_valid_out !== exp_rsp_valid || rsp_ready_in !== exp_rsp_ready) begin
                n_err++;
                $display("FAIL drain_rsp got=%b/%b exp=%b/%b", rsp_valid_out, rsp_ready_in, exp_rsp_valid, exp_rsp_ready);
            end
            clk_cycle();
            guard++;
        end
        idle();
        model_eval();
        n_vec++;
        if (busy !== 1'b0 || guard >= 40) begin
            n_err++;
            $display("FAIL drain_idle busy=%b exp=0 guard=%0d", busy, guard);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        req_ready_out = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 0);
        clk_cycle();
        clk_cycle();
        model_eval();
        n_vec++;
        if (req_ready_in !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready_in);
        end
        n_vec++;
        if (req_valid_out !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state valid_out=%b busy=%b exp=0/0", req_valid_out, busy);
        end
        idle();
        reset = 1'b0;
        clk_cycle();
        n_vec++;
        if (req_valid_out !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset valid_out=%b busy=%b exp=0/0", req_valid_out, busy);
        end
    endtask

    task automatic test_round_robin();
        req_ready_out = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 0);
            model_eval();
            n_vec++;
            if (req_ready_in !== exp_ready || req_ready_in !== 4'(1 << (k % N))) begin
                n_err++;
                $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready_in, 4'(1 << (k % N)));
            end
            if (k > 0) begin
                n_vec++;
                if (req_valid_out !== 1'b1 || req_tag_out[1:0] !== 2'(k - 1) || req_tag_out !== m_tag) begin
                    n_err++;
                    $display("FAIL rr_tag k=%0d got=%h exp=%h", k, req_tag_out, m_tag);
                end
            end
            clk_cycle();
        end
        drain();
    endtask

    task automatic test_credit_stall();
        logic [N-1:0] pat [4];
        pat[0] = 4'b0010; pat[1] = 4'b0010; pat[2] = 4'b0000; pat[3] = 4'b0000;
        idle();
        req_ready_out = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_req(1, 0);
            model_eval();
            n_vec++;
            if (req_ready_in !== exp_ready || req_ready_in !== pat[k]) begin
                n_err++;
                $display("FAIL credit_stall k=%0d got=%b exp=%b", k, req_ready_in, pat[k]);
            end
            clk_cycle();
        end
        rsp_valid_in = 1'b1;
        rsp_tag_in = {8'h11, 2'd1};
        rsp_ready_out = '1;
        model_eval();
        n_vec++;
        if (req_ready_in !== 4'b0000 || rsp_ready_in !== 1'b1) begin
            n_err++;
            $display("FAIL credit_rsp_cycle ready_in=%b rsp_ready=%b exp=0000/1", req_ready_in, rsp_ready_in);
        end
        clk_cycle();
        rsp_valid_in = 1'b0;
        model_eval();
        n_vec++;
        if (req_ready_in !== 4'b0010 || req_ready_in !== exp_ready) begin
            n_err++;
            $display("FAIL credit_release got=%b exp=0010", req_ready_in);
        end
        clk_cycle();
        drain();
    endtask

    task automatic test_stall_write();
        idle();
        req_ready_out = 1'b1;
        set_req(2, 1);
        clk_cycle();
        req_ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) set_req(i, (i == 2));
            model_eval();
            n_vec++;
            if (req_ready_in !== 4'b0000 || req_valid_out !== 1'b1 || req_rw_out !== 1'b1) begin
                n_err++;
                $display("FAIL stall_ctrl k=%0d ready_in=%b valid=%b rw=%b exp=0000/1/1", k, req_ready_in, req_valid_out, req_rw_out);
            end
            n_vec++;
            if ({req_byteen_out, req_addr_out, req_data_out, req_tag_out} !== {m_be, m_addr, m_data, m_tag}) begin
                n_err++;
                $display("FAIL stall_fields k=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", k,
                         req_byteen_out, req_addr_out, req_data_out, req_tag_out, m_be, m_addr, m_data, m_tag);
            end
            clk_cycle();
        end
        idle();
        req_ready_out = 1'b1;
        clk_cycle();
        model_eval();
        n_vec++;
        if (busy !== 1'b0 || req_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL write_no_credit busy=%b valid=%b exp=0/0", busy, req_valid_out);
        end
    endtask

    task automatic test_rsp_route();
        idle();
        req_ready_out = 1'b1;
        set_req(3, 0);
        clk_cycle();
        idle();
        clk_cycle();
        rsp_valid_in = 1'b1;
        rsp_tag_in = {8'h5A, 2'd3};
        rsp_data_in = 32'hCAFE_F00D;
        rsp_ready_out = 4'b0111;
        model_eval();
        n_vec++;
        if (rsp_valid_out !== 4'b1000 || rsp_ready_in !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rsp_blocked valid=%b ready=%b busy=%b exp=1000/0/1", rsp_valid_out, rsp_ready_in, busy);
        end
        n_vec++;
        if (rsp_tag_out[3*TW +: TW] !== 8'h5A || rsp_data_out[3*DW +: DW] !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL rsp_payload tag=%h data=%h exp=5a/cafef00d", rsp_tag_out[3*TW +: TW], rsp_data_out[3*DW +: DW]);
        end
        clk_cycle();
        rsp_ready_out = 4'b1000;
        model_eval();
        n_vec++;
        if (rsp_ready_in !== 1'b1 || rsp_valid_out !== 4'b1000) begin
            n_err++;
            $display("FAIL rsp_fire ready=%b valid=%b exp=1/1000", rsp_ready_in, rsp_valid_out);
        end
        clk_cycle();
        idle();
        model_eval();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_credit_return busy=%b exp=0", busy);
        end
    endtask

    task automatic test_same_cycle();
        logic [N-1:0] pat [4];
        pat[0] = 4'b0001; pat[1] = 4'b0001; pat[2] = 4'b0001; pat[3] = 4'b0000;
        idle();
        req_ready_out = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            set_req(0, 0);
            if (k == 1) begin
                rsp_valid_in = 1'b1;
                rsp_tag_in = {8'h33, 2'd0};
                rsp_ready_out = '1;
            end
            model_eval();
            n_vec++;
            if (req_ready_in !== exp_ready || req_ready_in !== pat[k]) begin
                n_err++;
                $display("FAIL same_cycle k=%0d got=%b exp=%b", k, req_ready_in, pat[k]);
            end
            clk_cycle();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        idle();
        req_ready_out = 1'b0;
        set_req(2, 0);
        clk_cycle();
        idle();
        reset = 1'b1;
        clk_cycle();
        reset = 1'b0;
        model_eval();
        n_vec++;
        if (req_valid_out !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid valid=%b busy=%b exp=0/0", req_valid_out, busy);
        end
        req_ready_out = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 0);
        model_eval();
        n_vec++;
        if (req_ready_in !== 4'b0001 || req_ready_in !== exp_ready) begin
            n_err++;
            $display("FAIL reset_mid_rr got=%b exp=0001", req_ready_in);
        end
        clk_cycle();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int cands [$];
            idle();
            for (int i = 0; i < N; i++) if ($urandom_range(0, 2) != 0) set_req(i, $urandom_range(0, 3) == 0);
            req_ready_out = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) if (m_cnt[i] > 0) cands.push_back(i);
            if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
                rsp_valid_in = 1'b1;
                rsp_tag_in = {TW'($urandom), 2'(cands[$urandom_range(0, cands.size() - 1)])};
                rsp_data_in = $urandom;
            end
            rsp_ready_out = N'($urandom);
            model_eval();
            n_vec++;
            if (req_ready_in !== exp_ready) begin
                n_err++;
                $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready_in, exp_ready);
            end
            n_vec++;
            if (req_valid_out !== m_sv || busy !== exp_busy) begin
                n_err++;
                $display("FAIL rand_state c=%0d valid=%b busy=%b exp=%b/%b", c, req_valid_out, busy, m_sv, exp_busy);
            end
            if (m_sv) begin
                n_vec++;
                if ({req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} !== {m_rw, m_be, m_addr, m_data, m_tag}) begin
                    n_err++;
                    $display("FAIL rand_out c=%0d got=%b/%h/%h/%h/%h exp=%b/%h/%h/%h/%h", c, req_rw_out, req_byteen_out,
                             req_addr_out, req_data_out, req_tag_out, m_rw, m_be, m_addr, m_data, m_tag);
                end
            end
            n_vec++;
            if (rsp_valid_out !== exp_rsp_valid || rsp_ready_in !== exp_rsp_ready) begin
                n_err++;
                $display("FAIL rand_rsp c=%0d got=%b/%b exp=%b/%b", c, rsp_valid_out, rsp_ready_in, exp_rsp_valid, exp_rsp_ready);
            end
            clk_cycle();
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        req_byteen_in = '0;
        req_addr_in = '0;
        req_data_in = '0;
        req_tag_in = '0;
        req_ready_out = 1'b0;
        idle();
        model_clear();
        test_reset();
        test_round_robin();
        test_credit_stall();
        test_stall_write();
        test_rsp_route();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
